// File: rtl/oport_uart_tx.sv
// Output-port UART transmitter: queues bytes written by the CPU and sends each one
// as an 8N1 frame, LSB first. Frames queued back-to-back go out with no idle gap.
module oport_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]  state;
    logic [7:0]  baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        baud_wrap;
    logic        push;
    logic        pop;

    // Write side has no ready: wr_en is a one-cycle strobe that is accepted when the
    // registered full is low and otherwise dropped, which raises the sticky overflow.
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign busy      = (state != ST_IDLE) || !empty;
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign push      = wr_en && !full;
    assign pop       = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && baud_wrap));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A dropped write takes priority over a coincident clear.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit when more bytes wait.
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift[0];
            default:  tx = 1'b1;
        endcase
    end

endmodule
